// File: rtl/ucsbece154b_fetch_stage.sv
// Instruction fetch stage with a variable-latency instruction memory port.
// The PC register drives the memory address directly. A small FSM holds a
// response that arrives while F is stalled, or drops a late response that
// belongs to a redirected (wrong-path) request. The F/D pipeline register is
// updated here with flush/stall priority.
module ucsbece154b_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0001_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o,
  output logic        FetchStall_o
);

  // FETCH: request outstanding at PCF
  // HOLD : response captured in holdBuf, waiting for StallF to drop
  // DROP : request outstanding is wrong-path; discard it, then go to redirectPC
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [31:0] PCF, PCFNext;
  logic [31:0] holdBuf, holdBufNext;
  logic [31:0] redirectPC, redirectPCNext;

  logic [31:0] PCPlus4F;
  logic [31:0] targetAligned;
  logic        fetchValid;
  logic [31:0] fetchInstr;

  // Address arithmetic wraps naturally at 32 bits; targets are forced word aligned.
  assign PCPlus4F      = PCF + 32'd4;
  assign targetAligned = PCTargetE_i & 32'hFFFF_FFFC;

  // Memory request follows PCF, which only moves on a completed or discarded response.
  assign imem_addr_o  = PCF;
  assign imem_req_o   = (state != HOLD);
  assign FetchStall_o = (state == DROP) || ((state == FETCH) && !imem_ready_i);

  // State, PC and side-buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      PCF        <= RESET_PC;
      holdBuf    <= 32'd0;
      redirectPC <= 32'd0;
    end else begin
      state      <= stateNext;
      PCF        <= PCFNext;
      holdBuf    <= holdBufNext;
      redirectPC <= redirectPCNext;
    end
  end

  // Next-state logic; a redirect always wins over a stall.
  always_comb begin
    stateNext      = state;
    PCFNext        = PCF;
    holdBufNext    = holdBuf;
    redirectPCNext = redirectPC;
    fetchValid     = 1'b0;
    fetchInstr     = NOP_INSTR;
    case (state)
      FETCH: begin
        if (PCSrcE_i) begin
          if (imem_ready_i) begin
            // response is wrong-path, can retarget immediately
            PCFNext = targetAligned;
          end else begin
            // request still in flight; keep address stable until it returns
            redirectPCNext = targetAligned;
            stateNext      = DROP;
          end
        end else if (imem_ready_i) begin
          if (StallF_i) begin
            holdBufNext = imem_rdata_i;
            stateNext   = HOLD;
          end else begin
            fetchValid = 1'b1;
            fetchInstr = imem_rdata_i;
            PCFNext    = PCPlus4F;
          end
        end
      end
      HOLD: begin
        if (PCSrcE_i) begin
          PCFNext   = targetAligned;
          stateNext = FETCH;
        end else if (!StallF_i) begin
          fetchValid = 1'b1;
          fetchInstr = holdBuf;
          PCFNext    = PCPlus4F;
          stateNext  = FETCH;
        end
      end
      DROP: begin
        // a newer redirect replaces the pending one
        if (PCSrcE_i) redirectPCNext = targetAligned;
        if (imem_ready_i) begin
          PCFNext   = redirectPCNext;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  // F/D register: flush beats stall beats load; no fetched instruction loads a bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushD_i) begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= 32'd0;
      PCPlus4D_o <= 32'd0;
      ValidD_o   <= 1'b0;
    end else if (!StallD_i) begin
      if (fetchValid) begin
        InstrD_o   <= fetchInstr;
        PCD_o      <= PCF;
        PCPlus4D_o <= PCPlus4F;
        ValidD_o   <= 1'b1;
      end else begin
        InstrD_o   <= NOP_INSTR;
        PCD_o      <= 32'd0;
        PCPlus4D_o <= 32'd0;
        ValidD_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_stage.sv
// Bench for the fetch stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model through two scoreboard queues.
module tb_ucsbece154b_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0001_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF_i = 1'b0, StallD_i = 1'b0, FlushD_i = 1'b0, PCSrcE_i = 1'b0;
  logic [31:0] PCTargetE_i = 32'd0;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        imem_req_o, ValidD_o, FetchStall_o;
  logic [31:0] imem_addr_o, InstrD_o, PCD_o, PCPlus4D_o;

  ucsbece154b_fetch_stage dut (
    .clk(clk), .reset(reset),
    .StallF_i(StallF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
    .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
    .ValidD_o(ValidD_o), .FetchStall_o(FetchStall_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic req; logic fs; } comb_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; logic v; } fd_t;

  comb_t qC[$];
  fd_t   qF[$];
  int    nChk = 0;
  int    nErr = 0;

  // Reference model: next PC, an optional captured instruction, an optional
  // pending redirect target, and the expected decode-stage contents.
  logic [31:0] mPc = 32'd0;
  bit          mBufV = 0;
  logic [31:0] mBuf = 32'd0;
  bit          mDropV = 0;
  logic [31:0] mDropT = 32'd0;
  fd_t         mFd;
  bit          mKnown = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record what the DUT must show.
  task automatic step(input bit rst, input bit sF, input bit sD, input bit fD,
                      input bit br, input logic [31:0] tgt, input bit rdy,
                      input logic [31:0] rd);
    logic [31:0] t, ins, ipc;
    bit          have;
    fd_t         bub;
    @(negedge clk);
    reset = rst; StallF_i = sF; StallD_i = sD; FlushD_i = fD;
    PCSrcE_i = br; PCTargetE_i = tgt; imem_ready_i = rdy; imem_rdata_i = rd;
    if (mKnown) qC.push_back('{mPc, !mBufV, mDropV || (!mBufV && !rdy)});
    bub  = '{NOP, 32'd0, 32'd0, 1'b0};
    t    = tgt & 32'hFFFF_FFFC;
    have = 0; ins = NOP; ipc = 32'd0;
    if (rst) begin
      mPc = RST_PC; mBufV = 0; mDropV = 0; mFd = bub; mKnown = 1;
    end else begin
      if (mDropV) begin
        if (br) mDropT = t;
        if (rdy) begin mPc = mDropT; mDropV = 0; end
      end else if (mBufV) begin
        if (br) begin mPc = t; mBufV = 0; end
        else if (!sF) begin have = 1; ins = mBuf; ipc = mPc; mPc = mPc + 32'd4; mBufV = 0; end
      end else if (br) begin
        if (rdy) mPc = t;
        else begin mDropV = 1; mDropT = t; end
      end else if (rdy) begin
        if (sF) begin mBufV = 1; mBuf = rd; end
        else begin have = 1; ins = rd; ipc = mPc; mPc = mPc + 32'd4; end
      end
      if (fD) mFd = bub;
      else if (!sD) mFd = have ? '{ins, ipc, ipc + 32'd4, 1'b1} : bub;
    end
    if (mKnown) qF.push_back(mFd);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  // Monitor for combinational fetch-side outputs, sampled mid-low-phase.
  initial begin
    comb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qC.size() > 0) begin
        e = qC.pop_front();
        cmp("sb_imem_addr", imem_addr_o, e.addr);
        cmp("sb_imem_req", 32'(imem_req_o), 32'(e.req));
        cmp("sb_fetch_stall", 32'(FetchStall_o), 32'(e.fs));
      end
    end
  end

  // Monitor for the F/D register, sampled just after the rising edge.
  initial begin
    fd_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qF.size() > 0) begin
        e = qF.pop_front();
        cmp("sb_InstrD", InstrD_o, e.instr);
        cmp("sb_PCD", PCD_o, e.pc);
        cmp("sb_PCPlus4D", PCPlus4D_o, e.pc4);
        cmp("sb_ValidD", 32'(ValidD_o), 32'(e.v));
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    // reset state
    step(1, 0, 0, 0, 0, 32'd0, 0, 32'd0); post();
    step(1, 0, 0, 0, 0, 32'd0, 1, 32'hDEAD_BEEF); post();
    cmp("rst_InstrD", InstrD_o, NOP);
    cmp("rst_ValidD", 32'(ValidD_o), 32'd0);
    cmp("rst_PCD", PCD_o, 32'd0);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 32'd0, 1, $urandom);
      #1;
      cmp("stream_addr", imem_addr_o, RST_PC + 32'(4 * i));
      cmp("stream_req", 32'(imem_req_o), 32'd1);
      post();
      cmp("stream_PCD", PCD_o, RST_PC + 32'(4 * i));
      cmp("stream_ValidD", 32'(ValidD_o), 32'd1);
    end

    // response captured while stalled, released later
    step(0, 1, 1, 0, 0, 32'd0, 1, 32'h0050_0093); post();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0, 32'd0, 0, $urandom);
      #1;
      cmp("hold_req", 32'(imem_req_o), 32'd0);
      post();
    end
    step(0, 0, 0, 0, 0, 32'd0, 0, $urandom); post();
    cmp("hold_InstrD", InstrD_o, 32'h0050_0093);
    cmp("hold_ValidD", 32'(ValidD_o), 32'd1);
    cmp("hold_PCD", PCD_o, 32'h0001_0010);
    step(0, 0, 0, 0, 0, 32'd0, 0, $urandom);
    #1;
    cmp("hold_next_addr", imem_addr_o, 32'h0001_0014);
    post();

    // redirect during an outstanding request
    step(0, 0, 0, 0, 1, 32'h0001_0008, 1, $urandom); post();
    step(0, 0, 0, 0, 1, 32'h0001_0100, 0, $urandom);
    #1; cmp("drop_addr0", imem_addr_o, 32'h0001_0008);
    post(); cmp("drop_valid0", 32'(ValidD_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 32'd0, 0, $urandom);
      #1;
      cmp("drop_addr_stable", imem_addr_o, 32'h0001_0008);
      cmp("drop_fstall", 32'(FetchStall_o), 32'd1);
      post(); cmp("drop_valid", 32'(ValidD_o), 32'd0);
    end
    step(0, 0, 0, 0, 0, 32'd0, 1, $urandom);
    #1; cmp("drop_fstall_ready", 32'(FetchStall_o), 32'd1);
    post(); cmp("drop_valid_late", 32'(ValidD_o), 32'd0);
    step(0, 0, 0, 0, 0, 32'd0, 0, $urandom);
    #1; cmp("drop_target_addr", imem_addr_o, 32'h0001_0100);
    post();

    // flush beats stall
    step(0, 0, 0, 0, 0, 32'd0, 1, $urandom); post();
    step(0, 0, 1, 1, 0, 32'd0, 1, $urandom); post();
    cmp("flush_InstrD", InstrD_o, NOP);
    cmp("flush_ValidD", 32'(ValidD_o), 32'd0);

    // unaligned target masking and PC wrap
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, $urandom); post();
    step(0, 0, 0, 0, 0, 32'd0, 1, $urandom);
    #1; cmp("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    post();
    cmp("wrap_PCD", PCD_o, 32'hFFFF_FFFC);
    cmp("wrap_PCPlus4D", PCPlus4D_o, 32'd0);
    step(0, 0, 0, 0, 0, 32'd0, 0, $urandom);
    #1; cmp("wrap_addr_zero", imem_addr_o, 32'd0);
    post();

    // reset while dropping
    step(0, 0, 0, 0, 1, 32'h0000_2000, 0, $urandom); post();
    step(1, 0, 0, 0, 0, 32'd0, 1, $urandom);
    #1; cmp("rstdrop_fstall", 32'(FetchStall_o), 32'd1);
    post(); cmp("rstdrop_ValidD", 32'(ValidD_o), 32'd0);
    step(0, 0, 0, 0, 0, 32'd0, 0, $urandom);
    #1;
    cmp("rstdrop_addr", imem_addr_o, RST_PC);
    cmp("rstdrop_req", 32'(imem_req_o), 32'd1);
    post();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, tgt,
           $urandom_range(0, 99) < 60, $urandom);
    end
    step(0, 0, 0, 0, 0, 32'd0, 0, 32'd0);

    repeat (3) @(posedge clk);
    #3;
    cmp("sb_drained", 32'(qC.size() + qF.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
